product_bcd_display: RTL and testbench

//  Downstream stage of the 4x4 shift-add multiplier. Captures the 8-bit product when the

---
 rtl/mult_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 18 +
 rtl/product_bcd_display.sv | 137 +++++++++++++
 tb/tb_product_bcd_display.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier display path.
// No logic; helper function is combinational.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   localparam int BCD_DIGITS = 3;
   localparam int PRODUCT_W  = 8;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   function automatic logic [3:0] dabble_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern; blank or non-decimal input lights nothing.
// Latency: combinational. Backpressure: none.
// Flow: pure function of its inputs.
module seg7_decode
   import mult_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK;
      if (!blank && digit <= 4'd9)
         pattern = SEG_DIGIT[digit];
   end

endmodule

// File: rtl/product_bcd_display.sv
// Captures multiplier product on ready rise, double-dabbles it to 3 BCD digits, muxes a 7-seg display.
// Latency: rise at edge N -> bcd/bcd_valid after edge N+9. Backpressure: none; rises while busy are dropped.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module product_bcd_display
   import mult_pkg::*;
#(
   parameter int REFRESH_DIV    = 1024,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ready,
   input  logic [PRODUCT_W-1:0]    product,
   output logic                    busy,
   output logic                    bcd_valid,
   output logic [4*BCD_DIGITS-1:0] bcd,
   output logic [6:0]              seg,
   output logic [BCD_DIGITS-1:0]   dig_sel
);

   localparam int SR_W  = 4*BCD_DIGITS + PRODUCT_W;
   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   conv_state_t      state;
   logic             ready_q;
   logic             rise;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_adj;
   logic [2:0]       iter;

   assign rise   = ready & ~ready_q;
   assign sr_adj = {dabble_adj(sr[19:16]), dabble_adj(sr[15:12]),
                    dabble_adj(sr[11:8]), sr[7:0]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         ready_q   <= 1'b0;
         busy      <= 1'b0;
         bcd_valid <= 1'b0;
         bcd       <= '0;
         sr        <= '0;
         iter      <= '0;
      end else begin
         ready_q   <= ready;
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  sr    <= {{(4*BCD_DIGITS){1'b0}}, product};
                  iter  <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr   <= sr_adj << 1;
               iter <= iter + 3'd1;
               if (iter == 3'd7)
                  state <= DONE;
            end
            DONE: begin
               bcd       <= sr[SR_W-1:PRODUCT_W];
               bcd_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Display refresh runs regardless of conversion activity
   logic [CNT_W-1:0] refresh_cnt;
   logic [1:0]       digit_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   logic [3:0]            cur_digit;
   logic                  cur_blank;
   logic [6:0]            cur_pattern;
   logic [BCD_DIGITS-1:0] cur_onehot;

   always_comb begin
      cur_digit  = bcd[3:0];
      cur_blank  = 1'b0;
      cur_onehot = 3'b001;
      case (digit_idx)
         2'd1: begin
            cur_digit  = bcd[7:4];
            cur_onehot = 3'b010;
`ifdef LEADING_ZERO_BLANK_EN
            cur_blank  = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
`else
            cur_blank  = 1'b0;
`endif
         end
         2'd2: begin
            cur_digit  = bcd[11:8];
            cur_onehot = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
            cur_blank  = (bcd[11:8] == 4'd0);
`else
            cur_blank  = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   seg7_decode u_seg7 (
      .digit   (cur_digit),
      .blank   (cur_blank),
      .pattern (cur_pattern)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         seg     <= SEG_DIGIT[0] ^ {7{SEG_ACTIVE_LOW}};
         dig_sel <= 3'b001 ^ {3{SEG_ACTIVE_LOW}};
      end else begin
         seg     <= cur_pattern ^ {7{SEG_ACTIVE_LOW}};
         dig_sel <= cur_onehot ^ {3{SEG_ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_product_bcd_display.sv
// Bench for product_bcd_display: table + random conversions against an arithmetic model,
// drop-while-busy, reset abort, and display scan for both segment polarities.
module tb_product_bcd_display;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ready = 1'b0;
   logic [7:0]  product = 8'd0;

   logic        busy, bcd_valid;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;
   logic        busy_h, bcd_valid_h;
   logic [11:0] bcd_h;
   logic [6:0]  seg_h;
   logic [2:0]  dig_sel_h;

   int errors = 0;
   int checks = 0;
   int k = 0;

   product_bcd_display #(.REFRESH_DIV(D), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
      .clock(clock), .reset(reset), .ready(ready), .product(product),
      .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd), .seg(seg), .dig_sel(dig_sel)
   );

   product_bcd_display #(.REFRESH_DIV(D), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
      .clock(clock), .reset(reset), .ready(ready), .product(product),
      .busy(busy_h), .bcd_valid(bcd_valid_h), .bcd(bcd_h), .seg(seg_h), .dig_sel(dig_sel_h)
   );

   always #5 clock = ~clock;

   // Edges elapsed since the last reset edge
   always @(posedge clock) k <= reset ? 0 : k + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [11:0] model_bcd(input int p);
      return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
   endfunction

   function automatic logic [6:0] model_pat(input logic [11:0] b, input int i);
      logic [6:0] tbl [0:9];
      int         d;
      bit         blank;
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      d = (i == 0) ? int'(b[3:0]) : (i == 1) ? int'(b[7:4]) : int'(b[11:8]);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (i == 2 && b[11:8] == 4'd0) blank = 1'b1;
      if (i == 1 && b[11:8] == 4'd0 && b[7:4] == 4'd0) blank = 1'b1;
`endif
      return blank ? 7'h00 : tbl[d];
   endfunction

   // Full conversion; samples after edges N..N+11 where N is the edge that sees the rise
   task automatic convert(input logic [7:0] p, input string tag, input logic [11:0] exp);
      int vld_n, busy_n, vld_at;
      logic [11:0] res;
      vld_n = 0; busy_n = 0; vld_at = -1; res = 12'hFFF;
      @(negedge clock);
      product = p;
      ready = 1'b1;
      for (int e = 0; e <= 11; e++) begin
         @(negedge clock);
         if (busy) busy_n++;
         if (bcd_valid) begin
            vld_n++;
            vld_at = e;
            res = bcd;
         end
         if (e == 1) ready = 1'b0;
      end
      check({tag, "_bcd"}, res, exp);
      check({tag, "_bcd_hi"}, bcd_h, exp);
      check({tag, "_vld_pulses"}, vld_n, 1);
      check({tag, "_vld_edge"}, vld_at, 9);
      check({tag, "_busy_edges"}, busy_n, 9);
   endtask

   typedef struct {
      logic [7:0]  p;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int vld_n;
      logic [6:0] pat, inv7;
      logic [2:0] oh, inv3;
      int idx;

      vecs[0] = '{8'd35,  12'h035};
      vecs[1] = '{8'd255, 12'h255};
      vecs[2] = '{8'd0,   12'h000};
      vecs[3] = '{8'd99,  12'h099};
      vecs[4] = '{8'd100, 12'h100};
      vecs[5] = '{8'd9,   12'h009};
      vecs[6] = '{8'd10,  12'h010};
      vecs[7] = '{8'd199, 12'h199};

      repeat (3) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_bcd_valid", bcd_valid, 0);
      check("rst_bcd", bcd, 12'h000);
      check("rst_seg_lo", seg, 7'h40);
      check("rst_dig_lo", dig_sel, 3'b110);
      check("rst_seg_hi", seg_h, 7'h3F);
      check("rst_dig_hi", dig_sel_h, 3'b001);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      foreach (vecs[i]) convert(vecs[i].p, $sformatf("vec%0d", i), vecs[i].exp);

      for (int i = 0; i < 30; i++) begin
         logic [7:0] p;
         p = 8'($urandom_range(0, 255));
         convert(p, $sformatf("rnd%0d_%0d", i, p), model_bcd(int'(p)));
      end

      // Second rise three cycles into a conversion is dropped
      vld_n = 0;
      @(negedge clock);
      product = 8'd35;
      ready = 1'b1;
      for (int e = 0; e <= 24; e++) begin
         @(negedge clock);
         if (bcd_valid) vld_n++;
         if (e == 0) ready = 1'b0;
         if (e == 2) begin
            product = 8'd99;
            ready = 1'b1;
         end
      end
      ready = 1'b0;
      check("drop_vld_pulses", vld_n, 1);
      check("drop_bcd", bcd, 12'h035);

      // Display scan with bcd held at 035
      repeat (2) @(negedge clock);
      for (int s = 0; s < 3 * D * 2 + 2; s++) begin
         @(negedge clock);
         idx = ((k - 1) / D) % 3;
         pat = model_pat(12'h035, idx);
         oh = 3'(1 << idx);
         inv7 = ~pat;
         inv3 = ~oh;
         check($sformatf("disp_seg_hi_k%0d", k), seg_h, pat);
         check($sformatf("disp_dig_hi_k%0d", k), dig_sel_h, oh);
         check($sformatf("disp_seg_lo_k%0d", k), seg, inv7);
         check($sformatf("disp_dig_lo_k%0d", k), dig_sel, inv3);
         inv7 = ~seg_h;
         inv3 = ~dig_sel_h;
         check("disp_seg_polarity", seg, inv7);
         check("disp_dig_polarity", dig_sel, inv3);
      end

      // Reset in the middle of the shift phase aborts the conversion
      @(negedge clock);
      product = 8'd200;
      ready = 1'b1;
      for (int e = 0; e <= 4; e++) begin
         @(negedge clock);
         if (e == 1) ready = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy", busy, 0);
      check("abort_bcd", bcd, 12'h000);
      check("abort_vld", bcd_valid, 0);
      check("abort_dig_lo", dig_sel, 3'b110);
      reset = 1'b0;
      vld_n = 0;
      for (int e = 0; e < 12; e++) begin
         @(negedge clock);
         if (bcd_valid) vld_n++;
      end
      check("abort_no_vld", vld_n, 0);
      check("abort_bcd_held", bcd, 12'h000);
      convert(8'd123, "post_abort", 12'h123);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
